// File: rtl/rdma_pkg.sv
// Shared types for the RDMA header packer: FSM states, width defaults and a keep-mask helper.
package rdma_pkg;

  localparam int DEF_STREAM_WB = 64;
  localparam int MAX_WB        = 128;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    HDR   = 3'd1,
    BODY  = 3'd2,
    FLUSH = 3'd3,
    PASS  = 3'd4,
    DROP  = 3'd5
  } state_t;

  // Contiguous keep mask with the low n bits set.
  function automatic logic [MAX_WB-1:0] ones(input int n);
    logic [MAX_WB-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WB; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/rdma_byte_shifter.sv
// Combinational byte barrel shifter for a data/keep pair; direction fixed per instance.
// Zero latency, no flow control.
module rdma_byte_shifter #(
  parameter int STREAM_WB = 64,
  parameter int LEN_W     = $clog2(STREAM_WB) + 1,
  parameter bit LEFT      = 1'b1
) (
  input  logic [LEN_W-1:0]       amount,
  input  logic [STREAM_WB*8-1:0] src_data,
  input  logic [STREAM_WB-1:0]   src_keep,
  output logic [STREAM_WB*8-1:0] shf_data,
  output logic [STREAM_WB-1:0]   shf_keep
);

  logic [LEN_W+2:0] bit_amt;
  assign bit_amt = {amount, 3'b000};

  if (LEFT) begin : g_left
    assign shf_data = src_data << bit_amt;
    assign shf_keep = src_keep << amount;
  end else begin : g_right
    assign shf_data = src_data >> bit_amt;
    assign shf_keep = src_keep >> amount;
  end

endmodule

// File: rtl/rdma_hdr_packer.sv
// Closes the gap between a right-justified header beat and the payload; also passthrough/drop modes.
// Body/pass beats are combinational in->out with TREADY following AXIS_OUT_TREADY; a spill adds one FLUSH beat.
module rdma_hdr_packer
  import rdma_pkg::*;
#(
  parameter int STREAM_WB = DEF_STREAM_WB,
  parameter int LEN_W     = $clog2(STREAM_WB) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LEN_W-1:0]       cfg_hdr_len,
  input  logic [STREAM_WB*8-1:0] AXIS_IN_TDATA,
  input  logic [STREAM_WB-1:0]   AXIS_IN_TKEEP,
  input  logic                   AXIS_IN_TVALID,
  input  logic                   AXIS_IN_TLAST,
  output logic                   AXIS_IN_TREADY,
  output logic [STREAM_WB*8-1:0] AXIS_OUT_TDATA,
  output logic [STREAM_WB-1:0]   AXIS_OUT_TKEEP,
  output logic                   AXIS_OUT_TVALID,
  output logic                   AXIS_OUT_TLAST,
  input  logic                   AXIS_OUT_TREADY,
  output logic [31:0]            stat_pkt_count,
  output logic [15:0]            stat_drop_count,
  output logic                   stat_len_err
);

  localparam int DW = STREAM_WB * 8;
  localparam logic [LEN_W-1:0] WB_LEN = LEN_W'(STREAM_WB);

  typedef logic [STREAM_WB-1:0] keep_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  hdr_len;
  logic [LEN_W-1:0]  rem_len;
  logic [DW-1:0]     prior_data;
  keep_t             prior_keep;

  keep_t             hdr_keep;
  logic [DW-1:0]     hdr_mask;
  logic [DW-1:0]     shl_data, shr_data;
  keep_t             shl_keep, shr_keep;

  logic              in_rdy, out_vld, out_last;
  logic [DW-1:0]     out_dat;
  keep_t             out_keep;
  logic              load_hdr, load_tail, pkt_inc, drop_inc, set_err;

  assign rem_len  = WB_LEN - hdr_len;
  assign hdr_keep = keep_t'(ones(int'(cfg_hdr_len)));

  for (genvar i = 0; i < STREAM_WB; i++) begin : g_mask
    assign hdr_mask[8*i +: 8] = {8{hdr_keep[i]}};
  end

  // Incoming body bytes that land after the held header/tail bytes.
  rdma_byte_shifter #(.STREAM_WB(STREAM_WB), .LEN_W(LEN_W), .LEFT(1'b1)) u_merge (
    .amount   (hdr_len),
    .src_data (AXIS_IN_TDATA),
    .src_keep (AXIS_IN_TKEEP),
    .shf_data (shl_data),
    .shf_keep (shl_keep)
  );

  // Bytes that overflow the current output beat; shr_keep[0] is in_keep[R].
  rdma_byte_shifter #(.STREAM_WB(STREAM_WB), .LEN_W(LEN_W), .LEFT(1'b0)) u_spill (
    .amount   (rem_len),
    .src_data (AXIS_IN_TDATA),
    .src_keep (AXIS_IN_TKEEP),
    .shf_data (shr_data),
    .shf_keep (shr_keep)
  );

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    out_dat   = '0;
    out_keep  = '0;
    out_last  = 1'b0;
    load_hdr  = 1'b0;
    load_tail = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    set_err   = 1'b0;

    case (state)
      INIT: state_nxt = HDR;

      HDR: begin
        // A zero-length header forwards its own beat, so it must respect output backpressure.
        if (cfg_hdr_len == '0) begin
          in_rdy   = AXIS_OUT_TREADY;
          out_vld  = AXIS_IN_TVALID;
          out_dat  = AXIS_IN_TDATA;
          out_keep = AXIS_IN_TKEEP;
          out_last = AXIS_IN_TLAST;
        end else begin
          in_rdy = 1'b1;
        end
        if (AXIS_IN_TVALID && in_rdy) begin
          if (cfg_hdr_len == '0) begin
            if (AXIS_IN_TLAST) pkt_inc = 1'b1;
            else               state_nxt = PASS;
          end else if (cfg_hdr_len >= WB_LEN) begin
            set_err = 1'b1;
            if (AXIS_IN_TLAST) drop_inc = 1'b1;
            else               state_nxt = DROP;
          end else begin
            load_hdr  = 1'b1;
            state_nxt = AXIS_IN_TLAST ? FLUSH : BODY;
          end
        end
      end

      BODY: begin
        in_rdy   = AXIS_OUT_TREADY;
        out_vld  = AXIS_IN_TVALID;
        out_dat  = shl_data | prior_data;
        out_keep = shl_keep | prior_keep;
        out_last = AXIS_IN_TLAST && !shr_keep[0];
        if (AXIS_IN_TVALID && AXIS_OUT_TREADY) begin
          load_tail = 1'b1;
          if (AXIS_IN_TLAST) begin
            if (!shr_keep[0]) begin
              pkt_inc   = 1'b1;
              state_nxt = HDR;
            end else begin
              state_nxt = FLUSH;
            end
          end
        end
      end

      FLUSH: begin
        out_vld  = 1'b1;
        out_dat  = prior_data;
        out_keep = prior_keep;
        out_last = 1'b1;
        if (AXIS_OUT_TREADY) begin
          pkt_inc   = 1'b1;
          state_nxt = HDR;
        end
      end

      PASS: begin
        in_rdy   = AXIS_OUT_TREADY;
        out_vld  = AXIS_IN_TVALID;
        out_dat  = AXIS_IN_TDATA;
        out_keep = AXIS_IN_TKEEP;
        out_last = AXIS_IN_TLAST;
        if (AXIS_IN_TVALID && AXIS_OUT_TREADY && AXIS_IN_TLAST) begin
          pkt_inc   = 1'b1;
          state_nxt = HDR;
        end
      end

      DROP: begin
        in_rdy = 1'b1;
        if (AXIS_IN_TVALID && AXIS_IN_TLAST) begin
          drop_inc  = 1'b1;
          state_nxt = HDR;
        end
      end

      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= INIT;
      hdr_len         <= '0;
      prior_data      <= '0;
      prior_keep      <= '0;
      stat_pkt_count  <= '0;
      stat_drop_count <= '0;
      stat_len_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_hdr) begin
        hdr_len    <= cfg_hdr_len;
        prior_data <= AXIS_IN_TDATA & hdr_mask;
        prior_keep <= hdr_keep;
      end else if (load_tail) begin
        prior_data <= shr_data;
        prior_keep <= shr_keep;
      end
      if (pkt_inc)                                 stat_pkt_count  <= stat_pkt_count + 32'd1;
      if (drop_inc && stat_drop_count != 16'hFFFF) stat_drop_count <= stat_drop_count + 16'd1;
      if (set_err)                                 stat_len_err    <= 1'b1;
    end
  end

  assign AXIS_IN_TREADY  = in_rdy;
  assign AXIS_OUT_TVALID = out_vld;
  assign AXIS_OUT_TDATA  = out_dat;
  assign AXIS_OUT_TKEEP  = out_keep;
  assign AXIS_OUT_TLAST  = out_last;

endmodule

// File: doc/rdma_hdr_packer.md
# rdma_hdr_packer

Second-generation RDMA header packer. It sits between the RDMA header inserter and the QSFP/CMAC transmit path. It removes the byte gap between a right-justified header beat and the packet payload, and emits a dense AXI-Stream in which only the final beat can be sparse. It adds three things the first generation lacked:

- a run-time header length;
- tolerance of TVALID gaps mid-packet;
- passthrough and drop modes, plus statistics.

## Interface

Parameters:

- STREAM_WB, 64: stream width in bytes; power of two, 8 to 128.
- LEN_W, $clog2(STREAM_WB)+1: width of cfg_hdr_len.

Ports:

- clk  in  1  clock; everything is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_hdr_len  in  LEN_W  header length in bytes; sampled only on acceptance of a header beat.
- AXIS_IN_TDATA/TKEEP/TVALID/TLAST  in  STREAM_WB*8 / STREAM_WB / 1 / 1  input stream.
- AXIS_IN_TREADY  out  1  input ready.
- AXIS_OUT_TDATA/TKEEP/TVALID/TLAST  out  STREAM_WB*8 / STREAM_WB / 1 / 1  packed output stream.
- AXIS_OUT_TREADY  in  1  output ready.
- stat_pkt_count  out  32  packets emitted or passed through; wraps.
- stat_drop_count  out  16  packets dropped; saturates at 0xFFFF.
- stat_len_err  out  1  sticky flag; set on any dropped packet, cleared only by reset.

## Operation

- Conventions:
  - H is the header length latched at the header beat.
  - R = STREAM_WB − H.
  - TKEEP is contiguous from bit 0 on every beat.
  - prior_data/prior_keep is a STREAM_WB-wide holding register.
- INIT:
  - This is the state while reset is asserted and for 1 cycle afterwards.
  - TREADY=0, TVALID=0. Next state is HDR.
- HDR:
  - TREADY=1, TVALID=0.
  - The header is the low cfg_hdr_len bytes of the beat; upper bytes are discarded.
  - On accept with 1 ≤ len ≤ STREAM_WB−1:
    - prior_data ← beat masked to H bytes; prior_keep ← H ones.
    - If TLAST is set → FLUSH; otherwise → BODY.
  - On accept with len == 0 → PASS, and the same beat is forwarded (see PASS).
  - On accept with len ≥ STREAM_WB → DROP; stat_len_err is set.
- BODY:
  - TREADY = AXIS_OUT_TREADY; TVALID = AXIS_IN_TVALID (gaps propagate).
  - Output formation:
    - TDATA = (in << 8H) | prior_data[H bytes].
    - TKEEP = (in_keep << H) | prior_keep, truncated to STREAM_WB.
  - On a handshake, prior ← in >> 8R and prior_keep ← in_keep >> R.
  - On an accepted TLAST beat:
    - If in_keep[R] == 0, the output beat carries TLAST; the count increments and the next state is HDR.
    - Otherwise the output beat has no TLAST and the next state is FLUSH.
- FLUSH:
  - TREADY=0, TVALID=1, TDATA=prior_data, TKEEP=prior_keep, TLAST=1.
  - On handshake: count increments, next state is HDR.
- PASS:
  - Input maps straight to output; TREADY = AXIS_OUT_TREADY.
  - The HDR-state beat that selected PASS is forwarded in the same cycle. To allow this, in HDR TREADY is AXIS_OUT_TREADY whenever cfg_hdr_len == 0.
  - The accepted TLAST beat increments the count; next state is HDR.
- DROP:
  - TREADY=1, TVALID=0.
  - The accepted TLAST beat increments stat_drop_count; next state is HDR.
  - A header beat that already carried TLAST drops immediately; the state stays HDR and the count still increments.

## Timing

- Reset values: every output is 0 (TVALID, TREADY, TLAST, TDATA, TKEEP, all counters, stat_len_err). Asynchronous assertion forces INIT immediately; any in-flight packet is abandoned with no output TLAST.
- Latency:
  - BODY and PASS are combinational: the output appears in the same cycle as the input.
  - FLUSH adds exactly one beat.
  - The header beat produces no output beat, except in PASS.
- Handshake: output TDATA/TKEEP/TLAST are held stable while TVALID=1 and TREADY=0 (in BODY they are a function of the held input). No beat is ever lost or duplicated under any TREADY pattern.
- Back-to-back packets:
  - After a TLAST, the HDR state accepts a new header on the next cycle.
  - There is no bubble except the FLUSH beat.
- Simultaneous events: if stat_pkt_count wraps while a drop occurs, both counters update in the same cycle.

## Structure

- Package rdma_pkg holds:
  - the state enum {INIT, HDR, BODY, FLUSH, PASS, DROP};
  - STREAM_WB-derived localparams;
  - the keep-mask function ones(n).
- One sub-module, rdma_byte_shifter: combinational left/right byte barrel shifter for data and keep, parameterised by STREAM_WB with a LEN_W shift amount. It is instantiated twice (output merge and prior update).

## Test plan

All tests use STREAM_WB=64.

- H=50, 3-beat packet with last TKEEP=0xFF:
  - Output is 2 beats.
  - Beat 1 TKEEP=all ones: header plus body[0:13].
  - Beat 2 TKEEP=0x03FF_FFFF_FFFF_FFFF, TLAST=1.
  - 122 bytes in order; stat_pkt_count=1.
- H=50, last beat TKEEP=0xFFFFF (20 bytes):
  - Output is 3 beats.
  - The FLUSH beat has TKEEP=0x3F, TLAST=1.
- H=10, header beat with TLAST:
  - 1 output beat, TKEEP=0x3FF, TLAST=1.
- cfg_hdr_len=0: the packet is bit-exact passthrough, with random AXIS_OUT_TREADY (50%) and random input gaps; scoreboard shows no loss or duplication.
- cfg_hdr_len=64:
  - The 4-beat packet is absorbed with no output.
  - stat_drop_count=1, stat_len_err=1.
  - The next H=20 packet packs correctly.
- Reset asserted mid-BODY:
  - Outputs drop to 0 asynchronously.
  - TREADY stays 0 for 1 cycle after release.
  - The next packet is clean.
